control_panel_inputs: RTL and testbench

Front-panel input conditioner that sits directly upstream of `Washing_Machine`. It synchronises and debounces the raw push-buttons and turns them into clean single-cycle command pulses: `start`, `stop`, `pause`, `continue_signal`, `change_temperature` and `change_spin_speed`. It also holds the selected `wash_mode` and its `confirm_wash_mode` flag. All outputs connect one-to-one to the identically named `Washing_Machine` inputs.

---
 rtl/control_panel_inputs.sv | 167 ++++++++++++++++
 tb/tb_control_panel_inputs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/control_panel_inputs.sv
// Front-panel input conditioner for the washing machine controller.
// Each raw button is synchronised, debounced, edge-detected on press, and
// turned into gated single-cycle command pulses plus the held wash-mode state.
module control_panel_inputs #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned NUM_MODES       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_pause,
  input  logic       btn_continue,
  input  logic       btn_mode,
  input  logic       btn_confirm,
  input  logic       btn_temp,
  input  logic       btn_spin,
  input  logic       run_active,
  output logic       start,
  output logic       stop,
  output logic       pause,
  output logic       continue_signal,
  output logic       change_temperature,
  output logic       change_spin_speed,
  output logic [2:0] wash_mode,
  output logic       confirm_wash_mode
);

  localparam int unsigned NumBtn = 8;
  localparam int unsigned IdxStart   = 0;
  localparam int unsigned IdxStop    = 1;
  localparam int unsigned IdxPause   = 2;
  localparam int unsigned IdxCont    = 3;
  localparam int unsigned IdxMode    = 4;
  localparam int unsigned IdxConfirm = 5;
  localparam int unsigned IdxTemp    = 6;
  localparam int unsigned IdxSpin    = 7;

  // Counter value at which the next differing sample flips the stable level.
  localparam logic [7:0] CntLast  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] ModeLast = 3'(NUM_MODES - 1);

  logic [NumBtn-1:0] w_raw;
  logic [NumBtn-1:0] r_sync1;
  logic [NumBtn-1:0] r_sync2;
  logic [NumBtn-1:0] r_deb;
  logic [7:0]        r_cnt [NumBtn];
  logic [NumBtn-1:0] w_flip;
  logic [NumBtn-1:0] w_ev;

  logic       w_start_d;
  logic       w_stop_d;
  logic       w_pause_d;
  logic       w_cont_d;
  logic       w_temp_d;
  logic       w_spin_d;
  logic [2:0] w_mode_d;
  logic       w_conf_d;

  logic       r_start;
  logic       r_stop;
  logic       r_pause;
  logic       r_cont;
  logic       r_temp;
  logic       r_spin;
  logic [2:0] r_mode;
  logic       r_conf;

  assign w_raw = {btn_spin, btn_temp, btn_confirm, btn_mode,
                  btn_continue, btn_pause, btn_stop, btn_start};

  // Flip detection: a differing sample when the counter is one short of the
  // threshold; a press event is a flip while the stable level is still 0.
  always_comb begin
    w_flip = '0;
    w_ev   = '0;
    for (int i = 0; i < NumBtn; i++) begin
      w_flip[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CntLast);
      w_ev[i]   = w_flip[i] && !r_deb[i];
    end
  end

  // Two-flop synchronisers and per-button debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NumBtn; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (w_flip[i]) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Command gating and next wash-mode / confirm state from this cycle's events.
  always_comb begin
    w_stop_d  = w_ev[IdxStop];
    w_start_d = w_ev[IdxStart] && !w_ev[IdxStop] && !run_active && r_conf;
    // Pause and continue together are contradictory, so both are dropped.
    w_pause_d = w_ev[IdxPause] && !w_ev[IdxCont] && !w_ev[IdxStop] && run_active;
    w_cont_d  = w_ev[IdxCont] && !w_ev[IdxPause] && !w_ev[IdxStop] && run_active;
    w_temp_d  = w_ev[IdxTemp] && !run_active;
    w_spin_d  = w_ev[IdxSpin] && !run_active;

    w_mode_d = r_mode;
    w_conf_d = r_conf;
    if (!run_active) begin
      if (w_ev[IdxMode]) begin
        w_mode_d = (r_mode == ModeLast) ? 3'd0 : r_mode + 3'd1;
        w_conf_d = 1'b0;
      end else if (w_ev[IdxConfirm]) begin
        w_conf_d = 1'b1;
      end
    end
    if (w_ev[IdxStop]) begin
      w_conf_d = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_pause <= 1'b0;
      r_cont  <= 1'b0;
      r_temp  <= 1'b0;
      r_spin  <= 1'b0;
      r_mode  <= 3'd0;
      r_conf  <= 1'b0;
    end else begin
      r_start <= w_start_d;
      r_stop  <= w_stop_d;
      r_pause <= w_pause_d;
      r_cont  <= w_cont_d;
      r_temp  <= w_temp_d;
      r_spin  <= w_spin_d;
      r_mode  <= w_mode_d;
      r_conf  <= w_conf_d;
    end
  end

  assign start              = r_start;
  assign stop               = r_stop;
  assign pause              = r_pause;
  assign continue_signal    = r_cont;
  assign change_temperature = r_temp;
  assign change_spin_speed  = r_spin;
  assign wash_mode          = r_mode;
  assign confirm_wash_mode  = r_conf;

endmodule

// File: tb/tb_control_panel_inputs.sv
// Scoreboard bench for control_panel_inputs: each stimulus pushes the pulse
// vector and mode/confirm state expected at a known cycle; a negedge monitor
// compares every cycle against the queue head (or all-zero pulses otherwise).
module tb_control_panel_inputs;

  localparam int Deb = 4;
  localparam int Lat = Deb + 2;  // stimulus point to observing negedge
  localparam int Gap = 2 * Deb + 6;

  localparam logic [5:0] PStart = 6'b100000;
  localparam logic [5:0] PStop  = 6'b010000;
  localparam logic [5:0] PPause = 6'b001000;
  localparam logic [5:0] PCont  = 6'b000100;
  localparam logic [5:0] PTemp  = 6'b000010;
  localparam logic [5:0] PSpin  = 6'b000001;

  localparam logic [7:0] BStart = 8'h01;
  localparam logic [7:0] BStop  = 8'h02;
  localparam logic [7:0] BPause = 8'h04;
  localparam logic [7:0] BCont  = 8'h08;
  localparam logic [7:0] BMode  = 8'h10;
  localparam logic [7:0] BConf  = 8'h20;
  localparam logic [7:0] BTemp  = 8'h40;
  localparam logic [7:0] BSpin  = 8'h80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn = 8'hFF;
  logic       run_active = 1'b0;
  logic       start, stop, pause, cont, temp, spin;
  logic [2:0] wash_mode;
  logic       conf;

  control_panel_inputs #(
    .DEBOUNCE_CYCLES(Deb),
    .NUM_MODES      (5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_start         (btn[0]),
    .btn_stop          (btn[1]),
    .btn_pause         (btn[2]),
    .btn_continue      (btn[3]),
    .btn_mode          (btn[4]),
    .btn_confirm       (btn[5]),
    .btn_temp          (btn[6]),
    .btn_spin          (btn[7]),
    .run_active        (run_active),
    .start             (start),
    .stop              (stop),
    .pause             (pause),
    .continue_signal   (cont),
    .change_temperature(temp),
    .change_spin_speed (spin),
    .wash_mode         (wash_mode),
    .confirm_wash_mode (conf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] pulses;
    logic [2:0] mode;
    logic       conf;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [2:0] exp_mode = 3'd0;
  logic       exp_conf = 1'b0;
  logic [5:0] ep;
  exp_t       it;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input logic [5:0] p, input logic [2:0] m, input logic c);
    exp_t e;
    e.cyc    = cyc + Lat;
    e.pulses = p;
    e.mode   = m;
    e.conf   = c;
    q.push_back(e);
  endtask

  task automatic press(input logic [7:0] mask, input int hold);
    btn = mask;
    step(hold);
    btn = 8'h00;
    step(Gap);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(1);
    exp_mode = 3'd0;
    exp_conf = 1'b0;
    step(n - 1);
    reset = 1'b0;
  endtask

  // Monitor: one pulse/mode/confirm comparison per cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      ep = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        it       = q.pop_front();
        ep       = it.pulses;
        exp_mode = it.mode;
        exp_conf = it.conf;
      end
      check_eq("pulses", {26'd0, start, stop, pause, cont, temp, spin}, {26'd0, ep});
      check_eq("wash_mode", {29'd0, wash_mode}, {29'd0, exp_mode});
      check_eq("confirm", {31'd0, conf}, {31'd0, exp_conf});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every button held; outputs must read zero throughout.
    step(1);
    mon_en = 1'b1;
    step(2);
    reset = 1'b0;
    // Stop suppresses start/pause/continue; mode beats confirm; temp/spin pass.
    expect_at(PStop | PTemp | PSpin, 3'd1, 1'b0);
    step(Lat + 2);
    btn = 8'h00;
    step(Gap);

    // Short glitch on start: no pulse.
    press(BStart, 3);

    // Reset returns wash_mode to 0.
    do_reset(3);
    step(2);

    // Five mode presses wrap 1,2,3,4,0.
    for (int k = 1; k <= 5; k++) begin
      expect_at(6'd0, 3'(k % 5), 1'b0);
      press(BMode, 10);
    end
    expect_at(6'd0, 3'd0, 1'b1);
    press(BConf, 10);
    expect_at(6'd0, 3'd1, 1'b0);
    press(BMode, 10);

    // Start while unconfirmed is dropped.
    press(BStart, 20);

    // Confirm then a long start hold yields exactly one start.
    expect_at(6'd0, 3'd1, 1'b1);
    press(BConf, 10);
    expect_at(PStart, 3'd1, 1'b1);
    press(BStart, 20);

    // Running: mode/temp dropped, pause/continue pass.
    run_active = 1'b1;
    press(BMode, 10);
    press(BTemp, 10);
    press(BConf, 10);
    expect_at(PPause, 3'd1, 1'b1);
    press(BPause, 10);
    expect_at(PCont, 3'd1, 1'b1);
    press(BCont, 10);

    // Stop and pause together: only stop, confirm clears.
    expect_at(PStop, 3'd1, 1'b0);
    press(BStop | BPause, 10);
    // Pause and continue together: neither.
    press(BPause | BCont, 10);

    // Idle: pause dropped, temp and spin pass.
    run_active = 1'b0;
    press(BPause, 10);
    expect_at(PTemp, 3'd1, 1'b0);
    press(BTemp, 10);

    // Reset while the spin counter sits at 2, button kept held.
    btn = BSpin;
    step(4);
    do_reset(3);
    expect_at(PSpin, 3'd0, 1'b0);
    step(Lat + 2);
    btn = 8'h00;
    step(Gap);

    for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
    check_eq("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
